dequant9sx8u: RTL
=================

Name: dequant9sx8u

Overview:
- Inverse-quantization stage of the DCT datapath; the reconstruction side of the 12-bit-signed × 8-bit-unsigned quantizer multiplier.
- Takes 9-bit signed quantized coefficients in 64-coefficient blocks. Multiplies each by its step from an internal writable 64-entry table.
- Emits saturated 12-bit signed DCT coefficients to the IDCT through a fixed-latency, valid-qualified pipeline with block framing.

Parameters:
- LAT, 4, in_valid-to-out_valid latency in cycles; fixed, only 4 is supported.
- TBL_DEPTH, 64, quant table entries and coefficients per block.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  qcoef/in_sop qualified this cycle
- in_sop  input  1  marks coefficient 0 of a block; valid only with in_valid
- qcoef  input  9  quantized coefficient, two's complement
- tbl_we  input  1  quant table write strobe
- tbl_addr  input  6  table write address
- tbl_data  input  8  unsigned quant step; 0 is legal
- out_valid  output  1  coef qualified
- out_sop  output  1  first coefficient of block
- out_eop  output  1  last (64th) coefficient of block
- coef  output  12  dequantized coefficient, two's complement
- sat  output  1  coef was clipped this cycle
- frame_err  output  1  sticky: in_sop seen at index != 0

Behaviour:
- Reset (async, immediate): out_valid, out_sop, out_eop, sat, frame_err = 0; coef = 0; index counter = 0; all pipeline valids = 0. Table contents are not reset; a bench must load them before use.
- Index counter (6 bits):
  - in_valid & in_sop: this coefficient uses index 0; counter becomes 1.
  - in_valid & !in_sop: uses the current counter value, then increments; wraps 63->0.
  - No in_valid: counter holds.
- Framing errors:
  - in_sop with counter != 0: frame_err set, counter realigned to 0.
  - frame_err clears only on rst.
- Pipeline (no stall; in_valid may be high every cycle):
  - S1: register qcoef, the index, and sop flag; eop = (index==63). Table read is synchronous at that index. Convert qcoef to sign + 9-bit magnitude: -256 gives 256.
  - S2: product magnitude = mag × step, 17-bit unsigned.
  - S3: if magnitude exceeds the limit, clip and set sat. Limit is 2047 for positive and 2048 for negative. Otherwise apply sign by two's-complement negation.
  - S4: output register. out_valid = in_valid delayed by exactly 4 cycles, with sop/eop aligned to it.
- Zero handling: qcoef = 0 or step = 0 gives coef = 0 with sat = 0; the sign is never applied to zero.
- When out_valid = 0: coef, sat, out_sop, out_eop are all 0.
- Table write/read collision: a write and an S1 read of the same address in the same cycle return the old value. The write is visible from the next cycle.
- Table writes are legal at any time, including mid-block; they affect only coefficients read afterwards.
- rst mid-block: all in-flight coefficients are discarded and the next coefficient is treated as index 0.

Optional Feature:
- Macro DEQUANT_MIDRISE_EN.
- Defined: for nonzero qcoef, magnitude = ((2·|q| + 1) × step) >> 1, truncating, computed before sign and saturation. This reconstructs at the quantization interval midpoint. Latency remains 4.
- Not defined: magnitude = |q| × step exactly.
- Zero qcoef gives 0 in both builds.

Test Plan:
- Table all 16, block of qcoef 0..63 with in_sop on the first beat and in_valid continuous -> out_valid exactly 4 cycles later for 64 cycles; coef = 16·k; out_sop on k=0, out_eop on k=63; sat never set.
- tbl[5] = 200; qcoef = -3 at index 5 -> coef = -600 (0xDA8), sat = 0. With DEQUANT_MIDRISE_EN: -700 (0xD44).
- tbl[0] = 255; qcoef = 255 -> coef = 2047, sat = 1. qcoef = -256 -> coef = -2048 (0x800), sat = 1.
- Write tbl[2] = 9 in the same cycle index 2 is read (old value 4), qcoef = 10 -> coef = 40. Next block index 2, qcoef = 10 -> coef = 90.
- in_sop asserted at index 20 -> frame_err = 1 and stays 1. That coefficient is output with out_sop = 1 and uses tbl[0]. Following indices continue 1, 2, ...
- Assert rst for 1 cycle with 3 coefficients in flight -> outputs go to 0 immediately, no stale out_valid. The next in_valid without in_sop uses index 0.

Source files
------------

// File: rtl/dequant9sx8u_if.sv
// rtl/dequant9sx8u_if.sv - coefficient/table/output bundle for the dequantizer
//
// Purpose: groups the quantized-coefficient input, quant-table write port and
// dequantized output of dequant9sx8u into one interface.
// Modports:
//   master - drives in_valid/in_sop/qcoef and tbl_we/tbl_addr/tbl_data,
//            observes out_valid/out_sop/out_eop/coef/sat/frame_err
//   slave  - the dequantizer side (inputs and outputs reversed)
interface dequant9sx8u_if;
  logic        in_valid;
  logic        in_sop;
  logic [8:0]  qcoef;
  logic        tbl_we;
  logic [5:0]  tbl_addr;
  logic [7:0]  tbl_data;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic [11:0] coef;
  logic        sat;
  logic        frame_err;

  modport master (
    output in_valid, in_sop, qcoef, tbl_we, tbl_addr, tbl_data,
    input  out_valid, out_sop, out_eop, coef, sat, frame_err
  );

  modport slave (
    input  in_valid, in_sop, qcoef, tbl_we, tbl_addr, tbl_data,
    output out_valid, out_sop, out_eop, coef, sat, frame_err
  );
endinterface

// File: rtl/dequant9sx8u.sv
// rtl/dequant9sx8u.sv - 9-bit signed x 8-bit unsigned inverse quantizer, 4-stage pipeline
//
// Purpose: multiplies each 9-bit signed quantized coefficient by its step from
// a writable 64-entry table, saturates to 12-bit signed and emits it exactly 4
// cycles after it was accepted, with block start/end framing.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - dequant9sx8u_if.slave: in_valid/in_sop/qcoef in, tbl_we/tbl_addr/
//          tbl_data table write, out_valid/out_sop/out_eop/coef/sat out,
//          frame_err sticky framing error
// Build option: DEQUANT_MIDRISE_EN - reconstruct nonzero coefficients at the
//   quantization interval midpoint, ((2|q|+1)*step)>>1, instead of |q|*step.
module dequant9sx8u #(
  parameter int LAT       = 4,
  parameter int TBL_DEPTH = 64
) (
  input logic           clk,
  input logic           rst,
  dequant9sx8u_if.slave bus
);

  generate
    if (LAT != 4) begin : g_lat_chk
      $error("dequant9sx8u: only LAT=4 is supported");
    end
  endgenerate

  // Quant step table (not reset) and the S1 step register it feeds.
  logic [7:0]  tbl_q [TBL_DEPTH];
  logic [7:0]  s1_step_q;

  // Block index tracking.
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  idx_d;
  logic        ferr_q, ferr_d;

  // S1: sign/magnitude split.
  logic        s1_vld_q, s1_sop_q, s1_eop_q, s1_neg_q;
  logic [8:0]  s1_mag_q;
  logic [8:0]  mag_d;

  // S2: unsigned product.
  logic        s2_vld_q, s2_sop_q, s2_eop_q, s2_neg_q;
  logic [16:0] s2_mag_q, s2_mag_d;

  // S3: saturated, signed result.
  logic        s3_vld_q, s3_sop_q, s3_eop_q, s3_sat_q;
  logic [11:0] s3_coef_q;
  logic        s3_neg_eff;
  logic        s3_sat_d;
  logic [11:0] s3_coef_d;

  // S4: output register.
  logic        out_vld_q, out_sop_q, out_eop_q, out_sat_q;
  logic [11:0] out_coef_q;

  // Index selection: an in_sop always forces index 0 and realigns the
  // counter; seeing it anywhere but at counter 0 is a framing error.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = cnt_q;
    ferr_d = ferr_q;
    if (bus.in_valid) begin
      if (bus.in_sop) begin
        idx_d = 6'd0;
        cnt_d = 6'd1;
        if (cnt_q != 6'd0) ferr_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  // Two's-complement magnitude; -256 maps to 256, which still fits 9 bits.
  assign mag_d = bus.qcoef[8] ? (~bus.qcoef + 9'd1) : bus.qcoef;

  // Table write and synchronous read share the edge, so a read of the
  // address being written returns the old entry.
  always_ff @(posedge clk) begin
    if (bus.tbl_we) tbl_q[bus.tbl_addr] <= bus.tbl_data;
    s1_step_q <= tbl_q[idx_d];
  end

`ifdef DEQUANT_MIDRISE_EN
  // (2|q|+1)*step is at most 513*255, 17 bits; the >>1 is the [17:1] slice.
  logic [17:0] odd_prod;
  assign odd_prod = 18'({s1_mag_q, 1'b1}) * 18'(s1_step_q);
  assign s2_mag_d = (s1_mag_q == 9'd0) ? 17'd0 : odd_prod[17:1];
`else
  assign s2_mag_d = 17'(s1_mag_q) * 17'(s1_step_q);
`endif

  // A zero product never takes the negative path, so -0 cannot appear and
  // the asymmetric negative limit is never applied to it.
  assign s3_neg_eff = s2_neg_q && (s2_mag_q != 17'd0);

  always_comb begin
    s3_sat_d  = 1'b0;
    s3_coef_d = s2_mag_q[11:0];
    if (s3_neg_eff) begin
      if (s2_mag_q > 17'd2048) begin
        s3_sat_d  = 1'b1;
        s3_coef_d = 12'h800;
      end else begin
        s3_coef_d = ~s2_mag_q[11:0] + 12'd1;
      end
    end else if (s2_mag_q > 17'd2047) begin
      s3_sat_d  = 1'b1;
      s3_coef_d = 12'h7FF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 6'd0;
      ferr_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_sop_q   <= 1'b0;
      s1_eop_q   <= 1'b0;
      s1_neg_q   <= 1'b0;
      s1_mag_q   <= 9'd0;
      s2_vld_q   <= 1'b0;
      s2_sop_q   <= 1'b0;
      s2_eop_q   <= 1'b0;
      s2_neg_q   <= 1'b0;
      s2_mag_q   <= 17'd0;
      s3_vld_q   <= 1'b0;
      s3_sop_q   <= 1'b0;
      s3_eop_q   <= 1'b0;
      s3_sat_q   <= 1'b0;
      s3_coef_q  <= 12'd0;
      out_vld_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_sat_q  <= 1'b0;
      out_coef_q <= 12'd0;
    end else begin
      cnt_q      <= cnt_d;
      ferr_q     <= ferr_d;

      // Framing flags are qualified here so they are zero in idle slots.
      s1_vld_q   <= bus.in_valid;
      s1_sop_q   <= bus.in_valid & bus.in_sop;
      s1_eop_q   <= bus.in_valid & (idx_d == 6'd63);
      s1_neg_q   <= bus.qcoef[8];
      s1_mag_q   <= mag_d;

      s2_vld_q   <= s1_vld_q;
      s2_sop_q   <= s1_sop_q;
      s2_eop_q   <= s1_eop_q;
      s2_neg_q   <= s1_neg_q;
      s2_mag_q   <= s2_mag_d;

      // Data and sat are forced to zero on idle slots from here on.
      s3_vld_q   <= s2_vld_q;
      s3_sop_q   <= s2_sop_q;
      s3_eop_q   <= s2_eop_q;
      s3_sat_q   <= s2_vld_q & s3_sat_d;
      s3_coef_q  <= s2_vld_q ? s3_coef_d : 12'd0;

      out_vld_q  <= s3_vld_q;
      out_sop_q  <= s3_sop_q;
      out_eop_q  <= s3_eop_q;
      out_sat_q  <= s3_sat_q;
      out_coef_q <= s3_coef_q;
    end
  end

  assign bus.out_valid = out_vld_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.sat       = out_sat_q;
  assign bus.coef      = out_coef_q;
  assign bus.frame_err = ferr_q;

endmodule
